// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
package np_mem_pkg;
    localparam int WIDTH         = 32;
    localparam int ADDRSIZE      = 12;
    localparam int BURST_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Increment that sticks at lim once reached.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave: arbiter side, master: requesters + memory side.
interface mem_port_arbiter_if #(
    parameter int WIDTH    = np_mem_pkg::WIDTH,
    parameter int ADDRSIZE = np_mem_pkg::ADDRSIZE
);
    logic                r0_req, r0_wr, r0_gnt, r0_rvalid;
    logic [ADDRSIZE-1:0] r0_addr;
    logic [WIDTH-1:0]    r0_wdata, r0_rdata;
    logic                r1_req, r1_wr, r1_gnt, r1_rvalid;
    logic [ADDRSIZE-1:0] r1_addr;
    logic [WIDTH-1:0]    r1_wdata, r1_rdata;
    logic [ADDRSIZE-1:0] mem_address;
    logic [WIDTH-1:0]    mem_dataIn, mem_dataOut;
    logic                mem_wr;
    logic                owner;

    modport slave (
        input  r0_req, r0_wr, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_wr, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_address, mem_dataIn, mem_wr,
        input  mem_dataOut,
        output owner
    );

    modport master (
        output r0_req, r0_wr, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_wr, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_address, mem_dataIn, mem_wr,
        output mem_dataOut,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin picker with bounded bursts; purely combinational.
module arb_rr2
    import np_mem_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic [1:0] req,
    input  logic       last,
    input  arb_state_t owner,
    input  logic [7:0] burst_cnt,
    output logic [1:0] grant,
    output arb_state_t nxt_state,
    output logic [7:0] nxt_cnt,
    output logic       nxt_last
);
    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    logic cur, oth;

    // Choose who gets this cycle's access and where ownership goes next.
    always_comb begin
        grant     = '0;
        nxt_state = owner;
        nxt_cnt   = burst_cnt;
        nxt_last  = last;
        cur       = (owner == OWN1);
        oth       = ~cur;
        case (owner)
            IDLE: begin
                // A tie goes to the port that did not release last.
                if (req == 2'b11) begin
                    grant[~last] = 1'b1;
                    nxt_state    = last ? OWN0 : OWN1;
                    nxt_cnt      = 8'd1;
                end else if (req[0]) begin
                    grant[0]  = 1'b1;
                    nxt_state = OWN0;
                    nxt_cnt   = 8'd1;
                end else if (req[1]) begin
                    grant[1]  = 1'b1;
                    nxt_state = OWN1;
                    nxt_cnt   = 8'd1;
                end
            end
            OWN0, OWN1: begin
                if (!req[cur] && !req[oth]) begin
                    nxt_state = IDLE;
                    nxt_last  = cur;
                    nxt_cnt   = 8'd0;
                end else if (req[cur] && (!req[oth] || burst_cnt < BMAX)) begin
                    grant[cur] = 1'b1;
                    nxt_cnt    = sat_inc(burst_cnt, BMAX);
                end else begin
                    // Burst used up, or owner went quiet: hand over now.
                    grant[oth] = 1'b1;
                    nxt_state  = oth ? OWN1 : OWN0;
                    nxt_cnt    = 8'd1;
                    nxt_last   = cur;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the np core (port 0) and the
// packet loader (port 1). Optional statistics: define ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int WIDTH     = np_mem_pkg::WIDTH,
    parameter int ADDRSIZE  = np_mem_pkg::ADDRSIZE,
    parameter int BURST_MAX = np_mem_pkg::BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic [15:0]       wait_cnt1
`endif
);
    import np_mem_pkg::*;

    typedef struct packed {
        logic                wr;
        logic [ADDRSIZE-1:0] addr;
        logic [WIDTH-1:0]    wdata;
    } acc_t;

    arb_state_t state, nxt_state;
    logic       last, nxt_last, owner_q;
    logic [7:0] burst_cnt, nxt_cnt;
    logic [1:0] pick, gnt;
    logic       rvalid_q, rsel_q;
    acc_t       acc;

    arb_rr2 #(.BURST_MAX(BURST_MAX)) u_arb (
        .req       ({bus.r1_req, bus.r0_req}),
        .last      (last),
        .owner     (state),
        .burst_cnt (burst_cnt),
        .grant     (pick),
        .nxt_state (nxt_state),
        .nxt_cnt   (nxt_cnt),
        .nxt_last  (nxt_last)
    );

    // No access may leave the block while reset is held.
    assign gnt        = reset ? 2'b00 : pick;
    assign bus.r0_gnt = gnt[0];
    assign bus.r1_gnt = gnt[1];

    // Route the granted port onto the memory; all zero when idle.
    always_comb begin
        acc = '0;
        if (gnt[1])
            acc = '{wr: bus.r1_wr, addr: bus.r1_addr, wdata: bus.r1_wdata};
        else if (gnt[0])
            acc = '{wr: bus.r0_wr, addr: bus.r0_addr, wdata: bus.r0_wdata};
    end

    assign bus.mem_wr      = acc.wr;
    assign bus.mem_address = acc.addr;
    assign bus.mem_dataIn  = acc.wdata;

    // Ownership state, burst length and tie-break memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
            owner_q   <= 1'b0;
        end else begin
            state     <= nxt_state;
            last      <= nxt_last;
            burst_cnt <= nxt_cnt;
            owner_q   <= (nxt_state == OWN1);
        end
    end

    assign bus.owner = owner_q;

    // Remember which port's read is returning from memory next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            rvalid_q <= (|gnt) & ~acc.wr;
            if ((|gnt) && !acc.wr)
                rsel_q <= gnt[1];
        end
    end

    assign bus.r0_rvalid = rvalid_q & ~rsel_q;
    assign bus.r1_rvalid = rvalid_q &  rsel_q;
    assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_dataOut : '0;
    assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_dataOut : '0;

`ifdef ARB_STATS_EN
    // Saturating grant counters and port 1 wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
            wait_cnt1 <= '0;
        end else begin
            if (gnt[0] && gnt_cnt0 != 16'hFFFF)
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt[1] && gnt_cnt1 != 16'hFFFF)
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            if (bus.r1_req && !gnt[1] && wait_cnt1 != 16'hFFFF)
                wait_cnt1 <= wait_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
    localparam int BM = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, wait_cnt1;
`endif

    mem_port_arbiter #(.BURST_MAX(BM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
        .wait_cnt1 (wait_cnt1)
`endif
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {20'hA5C30, a};
    endfunction

    // Memory: synchronous write, registered read.
    bit [31:0] tmem  [4096];
    bit        wr_ok [4096];
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            tmem[bus.mem_address]  <= bus.mem_dataIn;
            wr_ok[bus.mem_address] <= 1'b1;
        end
        bus.mem_dataOut <= wr_ok[bus.mem_address] ? tmem[bus.mem_address]
                                                  : init_val(bus.mem_address);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner as int (-1 = nobody), run length, last releaser.
    logic [31:0] ref_mem [4096];
    int  m_own, m_run, m_last, m_rport, m_g0, m_g1, m_w1, last_g;
    bit  m_rv;
    logic [31:0] m_rdat;

    // Requesters
    bit          rq  [2];
    bit          rwr [2];
    logic [11:0] raddr [2];
    logic [31:0] rwd [2];

    task automatic model_reset();
        m_own = -1; m_run = 0; m_last = 1; m_rv = 0; m_rport = 0; m_rdat = '0;
        m_g0 = 0; m_g1 = 0; m_w1 = 0; last_g = -1;
    endtask

    function automatic int pick(input bit r0, input bit r1);
        bit mine, theirs;
        if (!r0 && !r1) return -1;
        if (m_own < 0) return (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
        mine   = (m_own == 0) ? r0 : r1;
        theirs = (m_own == 0) ? r1 : r0;
        if (mine && (!theirs || m_run < BM)) return m_own;
        return 1 - m_own;
    endfunction

    task automatic advance(input int g);
        if (g < 0) begin
            if (m_own >= 0) m_last = m_own;
            m_own = -1; m_run = 0;
        end else if (g == m_own) begin
            m_run = (m_run < BM) ? m_run + 1 : BM;
        end else begin
            if (m_own >= 0) m_last = m_own;
            m_own = g; m_run = 1;
        end
    endtask

    task automatic drive();
        bus.r0_req = rq[0]; bus.r0_wr = rwr[0]; bus.r0_addr = raddr[0]; bus.r0_wdata = rwd[0];
        bus.r1_req = rq[1]; bus.r1_wr = rwr[1]; bus.r1_addr = raddr[1]; bus.r1_wdata = rwd[1];
    endtask

    task automatic set_txn(input int p, input bit wr, input logic [11:0] a, input logic [31:0] d);
        rq[p] = 1'b1; rwr[p] = wr; raddr[p] = a; rwd[p] = d;
        drive();
    endtask

    // New random transactions; gap keeps a port quiet the cycle after a grant.
    task automatic next_reqs(input int p0, input int p1, input bit gap0, input bit gap1);
        int  pr [2];
        bit  gp [2];
        pr[0] = p0; pr[1] = p1; gp[0] = gap0; gp[1] = gap1;
        for (int i = 0; i < 2; i++) begin
            if (!rq[i] && !(gp[i] && last_g == i) && $urandom_range(0, 99) < pr[i]) begin
                rq[i]    = 1'b1;
                rwr[i]   = $urandom_range(0, 1) == 1;
                raddr[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF - 12'($urandom_range(0, 3))
                                                       : 12'($urandom_range(0, 31));
                rwd[i]   = $urandom;
            end
        end
        drive();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_r0_gnt"}, 32'(bus.r0_gnt), 0);
        chk({tag, "_r1_gnt"}, 32'(bus.r1_gnt), 0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
        chk({tag, "_mem_address"}, 32'(bus.mem_address), 0);
        chk({tag, "_mem_dataIn"}, bus.mem_dataIn, 0);
        chk({tag, "_r0_rvalid"}, 32'(bus.r0_rvalid), 0);
        chk({tag, "_r1_rvalid"}, 32'(bus.r1_rvalid), 0);
        chk({tag, "_r0_rdata"}, bus.r0_rdata, 0);
        chk({tag, "_r1_rdata"}, bus.r1_rdata, 0);
        chk({tag, "_owner"}, 32'(bus.owner), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq[0] = 0; rq[1] = 0;
        drive();
        #1;
        chk_zero("rst");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    // One clock: compare outputs against the model, then commit the model.
    task automatic cycle();
        int          g;
        bit          ew;
        logic [31:0] ea, ed;
        @(negedge clk);
        g  = pick(rq[0], rq[1]);
        ew = 0; ea = '0; ed = '0;
        if (g >= 0) begin
            ew = rwr[g]; ea = 32'(raddr[g]); ed = rwd[g];
        end
        chk("r0_gnt", 32'(bus.r0_gnt), 32'(g == 0));
        chk("r1_gnt", 32'(bus.r1_gnt), 32'(g == 1));
        chk("mem_wr", 32'(bus.mem_wr), 32'(ew));
        chk("mem_address", 32'(bus.mem_address), ea);
        chk("mem_dataIn", bus.mem_dataIn, ed);
        chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(m_rv && m_rport == 0));
        chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(m_rv && m_rport == 1));
        chk("r0_rdata", bus.r0_rdata, (m_rv && m_rport == 0) ? m_rdat : 32'd0);
        chk("r1_rdata", bus.r1_rdata, (m_rv && m_rport == 1) ? m_rdat : 32'd0);
        chk("owner", 32'(bus.owner), 32'(m_own == 1));
`ifdef ARB_STATS_EN
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_g0));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_g1));
        chk("wait_cnt1", 32'(wait_cnt1), 32'(m_w1));
`endif
        if (g == 0 && m_g0 < 65535) m_g0++;
        if (g == 1 && m_g1 < 65535) m_g1++;
        if (rq[1] && g != 1 && m_w1 < 65535) m_w1++;
        m_rv = (g >= 0) && !ew;
        if (m_rv) begin
            m_rport = g;
            m_rdat  = ref_mem[raddr[g]];
        end
        if (g >= 0 && ew) ref_mem[raddr[g]] = rwd[g];
        advance(g);
        last_g = g;
        @(posedge clk); #1;
        if (g >= 0) rq[g] = 1'b0;
        drive();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; rwr[i] = 0; raddr[i] = '0; rwd[i] = '0;
        end
        model_reset();
        do_reset();

        // Port 0 alone reads 0x010.
        set_txn(0, 1'b0, 12'h010, 32'h0);
        cycle(); cycle();

        // Tie from reset, release hand-over, and the following tie.
        do_reset();
        set_txn(0, 1'b0, 12'h020, 32'h0);
        set_txn(1, 1'b0, 12'h021, 32'h0);
        cycle(); cycle(); cycle();
        set_txn(0, 1'b1, 12'h022, 32'h11111111);
        set_txn(1, 1'b1, 12'h023, 32'h22222222);
        cycle(); cycle(); cycle();

        // 8:1 burst pattern: port 0 always asking, port 1 re-asks after one gap.
        do_reset();
        for (int c = 0; c < 90; c++) begin
            next_reqs(100, 100, 1'b0, 1'b1);
            cycle();
        end
        for (int c = 0; c < 4; c++) cycle();

        // Write at the top address, read it back immediately.
        set_txn(1, 1'b1, 12'hFFF, 32'h12345678);
        cycle();
        set_txn(0, 1'b0, 12'hFFF, 32'h0);
        cycle(); cycle(); cycle();

        // Reset right after a port 1 read grant drops the return.
        set_txn(1, 1'b0, 12'h005, 32'h0);
        @(negedge clk);
        chk("mid_r1_gnt", 32'(bus.r1_gnt), 1);
        reset = 1'b1;
        #1;
        chk_zero("mid");
        model_reset();
        rq[0] = 0; rq[1] = 0;
        drive();
        @(posedge clk); #1;
        chk("mid_r1_rvalid", 32'(bus.r1_rvalid), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        set_txn(1, 1'b0, 12'h006, 32'h0);
        cycle(); cycle();

        // Random traffic segments.
        for (int s = 0; s < 10; s++) begin
            int  p0, p1;
            bit  g0, g1;
            p0 = $urandom_range(0, 100);
            p1 = $urandom_range(0, 100);
            g0 = $urandom_range(0, 1) == 1;
            g1 = $urandom_range(0, 1) == 1;
            for (int c = 0; c < 80; c++) begin
                next_reqs(p0, p1, g0, g1);
                cycle();
            end
        end
        for (int c = 0; c < 4; c++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
